// File: rtl/sfifo_arb_pkg.sv
// Shared definitions for the sfifo write-port arbiter: FSM encoding and width helper.
package sfifo_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_ptr, modulo NREQ.
module rr_pick
   import sfifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_ptr_i,
   output logic            any_o,
   output logic [IDW-1:0]  idx_o
);

   logic [2*NREQ-1:0] dbl;
   int                start;
   int                sum;

   always_comb begin
      any_o = |req_i;
      idx_o = '0;
      sum   = 0;
      start = (int'(last_ptr_i) + 1) % NREQ;
      // Rotate so bit 0 is the highest-priority candidate; scan downwards so the lowest offset wins.
      dbl   = {req_i, req_i} >> start;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (dbl[k]) begin
            sum   = (start + k) % NREQ;
            idx_o = IDW'(sum);
         end
      end
   end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the sfifo write port among NREQ valid/ready requesters.
module sfifo_wr_arbiter
   import sfifo_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   parameter int IDW       = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_wfull,
   output logic                  fifo_winc,
   output logic [WIDTH-1:0]      fifo_wdata,
   output logic                  grant_vld,
   output logic [IDW-1:0]        grant_id
);

   localparam int              CNTW     = clog2(MAX_BURST) + 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
   localparam logic [IDW-1:0]  PTR_INIT = IDW'(NREQ - 1);

   logic [0:0]       state_q, state_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [CNTW-1:0]  burst_cnt_q, burst_cnt_d;
   logic [IDW-1:0]   last_ptr_q, last_ptr_d;

   logic             pick_any;
   logic [IDW-1:0]   pick_idx;
   logic             in_burst;
   logic             own_valid;
   logic             own_last;
   logic [WIDTH-1:0] own_data;
   logic             accept;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i      (req_valid),
      .last_ptr_i (last_ptr_q),
      .any_o      (pick_any),
      .idx_o      (pick_idx)
   );

   assign in_burst = (state_q == ST_BURST);

   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id_q == IDW'(i)) begin
            own_valid    = req_valid[i];
            own_last     = req_last[i];
            own_data     = req_data[i*WIDTH +: WIDTH];
            req_ready[i] = in_burst & ~fifo_wfull;
         end
      end
   end

   // Write strobe is combinational so a wfull arriving this cycle blocks the write immediately.
   assign accept     = in_burst & own_valid & ~fifo_wfull;
   assign fifo_winc  = accept;
   assign fifo_wdata = in_burst ? own_data : '0;
   assign grant_vld  = in_burst;
   assign grant_id   = grant_id_q;

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      last_ptr_d  = last_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_id_d  = pick_idx;
               burst_cnt_d = '0;
               state_d     = ST_BURST;
            end
         end
         default: begin
            if (!own_valid || (accept && (own_last || burst_cnt_q == CNT_LAST))) begin
               state_d     = ST_IDLE;
               last_ptr_d  = grant_id_q;
               burst_cnt_d = '0;
            end else if (accept) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
         last_ptr_q  <= PTR_INIT;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
         last_ptr_q  <= last_ptr_d;
      end
   end

endmodule
